// File: rtl/axil_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// axil_cfg_sequencer
//   AXI4-Lite master that loads NUM_CFG configuration words into an
//   accelerator register bank (word i at BASE_ADDR + 4*i), then polls the
//   status register at BASE_ADDR + STATUS_OFF until all DONE_MASK bits are set.
//   It reports the outcome as a one-cycle done pulse or a sticky error with a
//   code.
//
// Ports
//   ACLK, ARESETN         clock, asynchronous active-low reset
//   start                 one-cycle request, accepted only in IDLE
//   cfg_data              NUM_CFG packed 32-bit words, captured on accepted start
//   busy                  run in progress
//   done                  one-cycle success pulse
//   error, err_code       sticky failure flag and cause:
//                         01 = bad BRESP, 10 = bad RRESP, 11 = poll timeout
//   last_status           most recent status word read
//   m_axi_aw*/w*/b*       write address / data / response channels
//   m_axi_ar*/r*          read address / data channels
// -----------------------------------------------------------------------------
module axil_cfg_sequencer #(
  parameter int                ADDR_W     = 32,
  parameter int                NUM_CFG    = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_W-1:0] STATUS_OFF = 'hC,
  parameter logic [31:0]       DONE_MASK  = 32'h1,
  parameter int                POLL_GAP   = 16,
  parameter int                POLL_MAX   = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [32*NUM_CFG-1:0] cfg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [31:0]           last_status,
  // write address channel
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // write data channel
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // write response channel
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // read address channel
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // read data channel
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int IDX_W  = $clog2(NUM_CFG + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_POLL_WAIT, S_DONE, S_ERR
  } state_t;

  state_t state_reg, state_next;

  logic [32*NUM_CFG-1:0] cfg_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [POLL_W-1:0]     polls_reg;
  logic [GAP_W-1:0]      gap_reg;
  logic                  aw_done_reg;
  logic                  w_done_reg;
  logic                  error_reg;
  logic [1:0]            err_code_reg;
  logic [31:0]           last_status_reg;

  logic [31:0] cfg_word [NUM_CFG];
  logic [31:0] wdata_sel;
  logic        aw_ok, w_ok;
  logic        last_word, status_done, last_poll, gap_end;

  // Unpack the captured configuration vector into addressable words.
  for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg_word
    assign cfg_word[gi] = cfg_reg[32*gi +: 32];
  end

  always_comb begin
    wdata_sel = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (idx_reg == IDX_W'(i)) wdata_sel = cfg_word[i];
    end
  end

  // A channel counts as finished once it has handshaken in an earlier WR
  // cycle or is handshaking right now; WR exits only when both are finished.
  assign aw_ok = aw_done_reg | m_axi_awready;
  assign w_ok  = w_done_reg  | m_axi_wready;

  assign last_word   = (idx_reg == IDX_W'(NUM_CFG - 1));
  assign status_done = ((m_axi_rdata & DONE_MASK) == DONE_MASK);
  assign last_poll   = (polls_reg == POLL_W'(POLL_MAX - 1));
  assign gap_end     = (gap_reg == GAP_W'(POLL_GAP - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (start) state_next = S_WR;
      S_WR:        if (aw_ok && w_ok) state_next = S_WR_RESP;
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) state_next = S_ERR;
          else if (last_word)       state_next = S_RD_ADDR;
          else                      state_next = S_WR;
        end
      end
      S_RD_ADDR:   if (m_axi_arready) state_next = S_RD_DATA;
      S_RD_DATA: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00) state_next = S_ERR;
          else if (status_done)     state_next = S_DONE;
          else if (last_poll)       state_next = S_ERR;
          else                      state_next = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: if (gap_end) state_next = S_RD_ADDR;
      S_DONE:      state_next = S_IDLE;
      S_ERR:       state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (decoded from state; valids therefore drop asynchronously
  // with ARESETN because the state register does)
  // ---------------------------------------------------------------------------
  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_wdata   = '0;
    m_axi_araddr  = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_reg)
      S_WR: begin
        busy          = 1'b1;
        m_axi_awvalid = ~aw_done_reg;
        m_axi_wvalid  = ~w_done_reg;
        m_axi_awaddr  = BASE_ADDR + ADDR_W'({idx_reg, 2'b00});
        m_axi_wdata   = wdata_sel;
      end
      S_WR_RESP: begin
        busy         = 1'b1;
        m_axi_bready = 1'b1;
      end
      S_RD_ADDR: begin
        busy          = 1'b1;
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = BASE_ADDR + STATUS_OFF;
      end
      S_RD_DATA: begin
        busy         = 1'b1;
        m_axi_rready = 1'b1;
      end
      S_POLL_WAIT: busy = 1'b1;
      S_DONE:      done = 1'b1;
      default: ;
    endcase
  end

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;
  assign error        = error_reg;
  assign err_code     = err_code_reg;
  assign last_status  = last_status_reg;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cfg_reg         <= '0;
      idx_reg         <= '0;
      polls_reg       <= '0;
      gap_reg         <= '0;
      aw_done_reg     <= 1'b0;
      w_done_reg      <= 1'b0;
      error_reg       <= 1'b0;
      err_code_reg    <= 2'b00;
      last_status_reg <= '0;
    end else begin
      // Per-write handshake memory; it is only meaningful inside WR and is
      // cleared by the WR_RESP cycle that always separates two writes.
      aw_done_reg <= (state_reg == S_WR) && aw_ok;
      w_done_reg  <= (state_reg == S_WR) && w_ok;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            cfg_reg      <= cfg_data;
            error_reg    <= 1'b0;
            err_code_reg <= 2'b00;
            idx_reg      <= '0;
            polls_reg    <= '0;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            if (m_axi_bresp != 2'b00) begin
              error_reg    <= 1'b1;
              err_code_reg <= 2'b01;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end
        S_RD_DATA: begin
          gap_reg <= '0;
          if (m_axi_rvalid) begin
            last_status_reg <= m_axi_rdata;
            polls_reg       <= polls_reg + POLL_W'(1);
            if (m_axi_rresp != 2'b00) begin
              error_reg    <= 1'b1;
              err_code_reg <= 2'b10;
            end else if (!status_done && last_poll) begin
              error_reg    <= 1'b1;
              err_code_reg <= 2'b11;
            end
          end
        end
        S_POLL_WAIT: gap_reg <= gap_reg + GAP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_axil_cfg_sequencer
//   Directed bench: a reactive AXI4-Lite slave (decisions at the falling edge,
//   handshakes completing on the following rising edge) logs every transfer,
//   and the main sequence checks logged traffic and status outputs against
//   hand-computed values.
// -----------------------------------------------------------------------------
module tb_axil_cfg_sequencer;

  localparam int NUM_CFG  = 3;
  localparam int POLL_GAP = 4;
  localparam int POLL_MAX = 4;

  logic                  ACLK = 1'b0;
  logic                  ARESETN;
  logic                  start;
  logic [32*NUM_CFG-1:0] cfg_data;
  logic                  busy, done, error;
  logic [1:0]            err_code;
  logic [31:0]           last_status;
  logic [31:0]           m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [2:0]            m_axi_awprot, m_axi_arprot;
  logic [3:0]            m_axi_wstrb;
  logic                  m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]            m_axi_bresp, m_axi_rresp;
  logic                  m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic                  m_axi_rvalid, m_axi_rready;

  always #5 ACLK = ~ACLK;

  axil_cfg_sequencer #(
    .ADDR_W(32), .NUM_CFG(NUM_CFG), .BASE_ADDR(32'h0), .STATUS_OFF(32'hC),
    .DONE_MASK(32'h1), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .last_status(last_status),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // slave configuration (written by the main sequence only)
  int          aw_delay;
  int          bad_wr;
  int          bad_rd;
  int          status_len;
  logic [31:0] status_tab [0:7];

  // slave state and logs (written by the slave process only)
  int          cyc, aw_n, w_n, b_n, ar_n, r_n, aw_wait, aw_hi, w_hi;
  int          done_cnt, hold_viol, b_early;
  logic        aw_pend, w_pend, b_pend, ar_pend, r_pend;
  logic        prev_awv, prev_wv, prev_arv;
  logic [31:0] aw_addr_log [0:15];
  logic [31:0] w_data_log  [0:15];
  logic [31:0] ar_addr_log [0:15];
  int          aw_hold_log [0:15];
  int          w_hold_log  [0:15];
  int          ar_time     [0:15];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reactive slave
  // ---------------------------------------------------------------------------
  initial begin
    cyc = 0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (!ARESETN) begin
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        aw_wait = 0; aw_hi = 0; w_hi = 0;
        done_cnt = 0; hold_viol = 0; b_early = 0;
        aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
        prev_awv = 0; prev_wv = 0; prev_arv = 0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      end else begin
        // handshakes decided at the previous falling edge have now completed
        if (aw_pend) aw_n++;
        if (w_pend)  w_n++;
        if (b_pend)  b_n++;
        if (ar_pend) ar_n++;
        if (r_pend)  r_n++;
        // a valid may only fall right after its handshake
        if (prev_awv && !aw_pend && !m_axi_awvalid) hold_viol++;
        if (prev_wv  && !w_pend  && !m_axi_wvalid)  hold_viol++;
        if (prev_arv && !ar_pend && !m_axi_arvalid) hold_viol++;
        if (m_axi_bready && !(aw_n > b_n && w_n > b_n)) b_early++;
        if (done) done_cnt++;

        aw_pend = 1'b0;
        m_axi_awready = 1'b0;
        if (m_axi_awvalid) begin
          aw_hi++;
          if (aw_wait >= aw_delay) begin
            m_axi_awready = 1'b1;
            aw_pend = 1'b1;
            if (aw_n < 16) begin
              aw_addr_log[aw_n] = m_axi_awaddr;
              aw_hold_log[aw_n] = aw_hi;
            end
            aw_hi = 0; aw_wait = 0;
          end else begin
            aw_wait++;
          end
        end

        m_axi_wready = m_axi_wvalid;
        w_pend = m_axi_wvalid;
        if (m_axi_wvalid) begin
          w_hi++;
          if (w_n < 16) begin
            w_data_log[w_n] = m_axi_wdata;
            w_hold_log[w_n] = w_hi;
          end
          w_hi = 0;
        end

        if (aw_n > b_n && w_n > b_n) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = (b_n == bad_wr) ? 2'b10 : 2'b00;
          b_pend = m_axi_bready;
        end else begin
          m_axi_bvalid = 1'b0;
          m_axi_bresp  = 2'b00;
          b_pend = 1'b0;
        end

        m_axi_arready = m_axi_arvalid;
        ar_pend = m_axi_arvalid;
        if (m_axi_arvalid && ar_n < 16) begin
          ar_addr_log[ar_n] = m_axi_araddr;
          ar_time[ar_n]     = cyc;
        end

        if (ar_n > r_n) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = status_tab[(r_n < status_len) ? r_n : status_len - 1];
          m_axi_rresp  = (r_n == bad_rd) ? 2'b11 : 2'b00;
          r_pend = m_axi_rready;
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rresp  = 2'b00;
          r_pend = 1'b0;
        end

        prev_awv = m_axi_awvalid;
        prev_wv  = m_axi_wvalid;
        prev_arv = m_axi_arvalid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence helpers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic pulse_start(input logic [32*NUM_CFG-1:0] cfg);
    start    = 1'b1;
    cfg_data = cfg;
    @(negedge ACLK);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output logic got_done, output logic got_err);
    int i;
    got_done = 1'b0;
    got_err  = 1'b0;
    i = 0;
    while (i < budget && !got_done && !got_err) begin
      @(negedge ACLK);
      if (done)       got_done = 1'b1;
      else if (error) got_err  = 1'b1;
      i++;
    end
    if (!got_done && !got_err) check_eq("wait_end_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge ACLK);
  endtask

  task automatic set_slave(input int awd, input int bw, input int br);
    aw_delay = awd;
    bad_wr   = bw;
    bad_rd   = br;
  endtask

  logic gd, ge;
  int   found;

  initial begin
    ARESETN  = 1'b0;
    start    = 1'b0;
    cfg_data = '0;
    set_slave(0, 99, 99);
    status_tab[0] = 32'h0; status_tab[1] = 32'h0; status_tab[2] = 32'h1;
    for (int i = 3; i < 8; i++) status_tab[i] = 32'h1;
    status_len = 3;

    // ---- reset state (checked while ARESETN is still low)
    repeat (2) @(negedge ACLK);
    check_eq("rst_busy",   32'(busy), 32'd0);
    check_eq("rst_done",   32'(done), 32'd0);
    check_eq("rst_error",  32'(error), 32'd0);
    check_eq("rst_code",   32'(err_code), 32'd0);
    check_eq("rst_status", last_status, 32'd0);
    check_eq("rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                m_axi_arvalid, m_axi_rready}), 32'd0);

    // ---- 1: three writes, status 0,0,1 -> done
    do_reset();
    pulse_start({32'd3, 32'd2, 32'd1});
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_end(200, gd, ge);
    check_eq("t1_done",     32'(gd), 32'd1);
    check_eq("t1_aw_n",     aw_n, 32'd3);
    check_eq("t1_addr0",    aw_addr_log[0], 32'h0);
    check_eq("t1_addr1",    aw_addr_log[1], 32'h4);
    check_eq("t1_addr2",    aw_addr_log[2], 32'h8);
    check_eq("t1_data0",    w_data_log[0], 32'd1);
    check_eq("t1_data1",    w_data_log[1], 32'd2);
    check_eq("t1_data2",    w_data_log[2], 32'd3);
    check_eq("t1_ar_n",     ar_n, 32'd3);
    check_eq("t1_araddr",   ar_addr_log[2], 32'hC);
    check_eq("t1_gap",      ar_time[1] - ar_time[0], POLL_GAP + 2);
    check_eq("t1_status",   last_status, 32'd1);
    check_eq("t1_done_cnt", done_cnt, 32'd1);
    check_eq("t1_busy_end", 32'(busy), 32'd0);
    check_eq("t1_error",    32'(error), 32'd0);
    check_eq("t1_hold",     hold_viol, 32'd0);

    // ---- 2: awready delayed 3 cycles, wready immediate
    do_reset();
    set_slave(3, 99, 99);
    status_tab[0] = 32'h1; status_len = 1;
    pulse_start({32'hC0, 32'hB0, 32'hA0});
    wait_end(200, gd, ge);
    check_eq("t2_done",    32'(gd), 32'd1);
    check_eq("t2_aw_hold", aw_hold_log[0], 32'd4);
    check_eq("t2_w_hold",  w_hold_log[0], 32'd1);
    check_eq("t2_b_early", b_early, 32'd0);
    check_eq("t2_hold",    hold_viol, 32'd0);
    check_eq("t2_addr2",   aw_addr_log[2], 32'h8);
    check_eq("t2_data2",   w_data_log[2], 32'hC0);
    check_eq("t2_ar_n",    ar_n, 32'd1);

    // ---- 3: BRESP error on the second write, then a clean rerun
    do_reset();
    set_slave(0, 1, 99);
    pulse_start({32'd3, 32'd2, 32'd1});
    wait_end(200, gd, ge);
    check_eq("t3_err",      32'(ge), 32'd1);
    check_eq("t3_code",     32'(err_code), 32'd1);
    check_eq("t3_aw_n",     aw_n, 32'd2);
    check_eq("t3_ar_n",     ar_n, 32'd0);
    check_eq("t3_done_cnt", done_cnt, 32'd0);
    repeat (4) @(negedge ACLK);
    check_eq("t3_sticky",   32'(error), 32'd1);
    set_slave(0, 99, 99);
    pulse_start({32'd3, 32'd2, 32'd1});
    check_eq("t3_clr_err",  32'(error), 32'd0);
    check_eq("t3_clr_code", 32'(err_code), 32'd0);
    wait_end(200, gd, ge);
    check_eq("t3_rerun",    32'(gd), 32'd1);

    // ---- 4: status never done -> timeout after POLL_MAX reads
    do_reset();
    set_slave(0, 99, 99);
    status_tab[0] = 32'h0; status_len = 1;
    pulse_start({32'd3, 32'd2, 32'd1});
    wait_end(300, gd, ge);
    check_eq("t4_err",      32'(ge), 32'd1);
    check_eq("t4_code",     32'(err_code), 32'd3);
    check_eq("t4_ar_n",     ar_n, POLL_MAX);
    check_eq("t4_gap",      ar_time[3] - ar_time[2], POLL_GAP + 2);
    check_eq("t4_done_cnt", done_cnt, 32'd0);

    // ---- 5: second start while busy, reset during the second write
    do_reset();
    set_slave(3, 99, 99);
    status_tab[0] = 32'h1; status_len = 1;
    pulse_start({32'd3, 32'd2, 32'd1});
    pulse_start({32'd30, 32'd20, 32'd10});
    check_eq("t5_busy", 32'(busy), 32'd1);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge ACLK);
      if (aw_n >= 1 && m_axi_awvalid) found = 1;
    end
    check_eq("t5_in_wr2", found, 32'd1);
    repeat (2) @(negedge ACLK);
    check_eq("t5_w_n",     w_n, 32'd2);
    check_eq("t5_wdata1",  w_data_log[1], 32'd2);
    check_eq("t5_awvalid", 32'(m_axi_awvalid), 32'd1);
    #2 ARESETN = 1'b0;
    #1;
    check_eq("t5_rst_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                   m_axi_arvalid, m_axi_rready}), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (20) @(negedge ACLK);
    check_eq("t5_no_resume", aw_n, 32'd0);
    check_eq("t5_idle",      32'(busy), 32'd0);
    check_eq("t5_done_cnt",  done_cnt, 32'd0);

    // ---- 6: RRESP error on the first poll
    do_reset();
    set_slave(0, 99, 0);
    status_tab[0] = 32'hDEADBEEF; status_len = 1;
    pulse_start({32'd3, 32'd2, 32'd1});
    wait_end(200, gd, ge);
    check_eq("t6_err",      32'(ge), 32'd1);
    check_eq("t6_code",     32'(err_code), 32'd2);
    check_eq("t6_status",   last_status, 32'hDEADBEEF);
    check_eq("t6_ar_n",     ar_n, 32'd1);
    check_eq("t6_done_cnt", done_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
